// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encoding, requester indices, function codes
// and default sizes for the memory-port arbiter.
package mem_arbiter_pkg;

  // Default widths stand in for the memory unit's address/data widths.
  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 255;
  localparam int WAIT_CNT_W  = 8;
  localparam int IDX_W       = 2;

  // Memory function codes understood by the memory unit.
  localparam logic [1:0] GET_CONTENTS = 2'b01;
  localparam logic [1:0] SET_CONTENTS = 2'b10;

  // Requester indices.
  localparam logic [IDX_W-1:0] ARB_TRAV = 2'd0;
  localparam logic [IDX_W-1:0] ARB_EXEC = 2'd1;
  localparam logic [IDX_W-1:0] ARB_EDIT = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'h0,
    WAIT = 2'h1
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rr_picker: combinational rotate-priority encoder. Returns the first set
// pending bit found when searching upward from rr_ptr+1, wrapping at NUM_REQ.
module rr_picker
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   index
);

  logic [IDX_W-1:0] cand_idx;

  // Walk candidates from farthest to nearest so the nearest pending one is kept.
  always_comb begin
    valid    = 1'b0;
    index    = '0;
    cand_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand_idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (pending[cand_idx]) begin
        valid = 1'b1;
        index = cand_idx;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of the single memory-unit port between
// traversal, execute and edit requesters. Each request pulse is latched into
// a per-requester slot, one transaction is issued to memory at a time, and a
// one-cycle ready plus registered read data is returned to the owner.
// Optional macro ARB_LOCK_EN adds req_lock so an owner can hold the port
// across consecutive transactions (atomic read-modify-write).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_execute,
  input  logic [2*NUM_REQ-1:0]  req_func,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr1,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr2,
  input  logic [DATA_W*NUM_REQ-1:0] req_write_data,
`ifdef ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]    req_lock,
`endif
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [DATA_W-1:0]     read_data1,
  output logic [DATA_W-1:0]     read_data2,
  output logic                  mem_execute,
  output logic [1:0]            mem_func,
  output logic [ADDR_W-1:0]     address1,
  output logic [ADDR_W-1:0]     address2,
  output logic [DATA_W-1:0]     write_data,
  input  logic                  mem_ready,
  input  logic [DATA_W-1:0]     mem_read_data1,
  input  logic [DATA_W-1:0]     mem_read_data2,
  output logic [IDX_W-1:0]      grant_id,
  output logic                  busy,
  output logic [1:0]            arb_error
);

  arb_state_t              state;
  logic [NUM_REQ-1:0]      pending;
  logic [IDX_W-1:0]        rr_ptr;
  logic [WAIT_CNT_W-1:0]   wait_cnt;
  logic                    overflow_err;
  logic                    timeout_err;
  logic [1:0]              slot_func  [NUM_REQ];
  logic [ADDR_W-1:0]       slot_addr1 [NUM_REQ];
  logic [ADDR_W-1:0]       slot_addr2 [NUM_REQ];
  logic [DATA_W-1:0]       slot_wdata [NUM_REQ];
  logic [NUM_REQ-1:0]      owner_mask;
  logic [NUM_REQ-1:0]      pick_pending;
  logic                    pick_valid;
  logic [IDX_W-1:0]        pick_index;
  logic                    completing;

  assign owner_mask = NUM_REQ'(1) << grant_id;
  assign completing = (state == WAIT) &&
                      (mem_ready || (wait_cnt == WAIT_CNT_W'(TIMEOUT - 1)));
  assign busy       = (state != IDLE);
  assign arb_error  = {timeout_err, overflow_err};

`ifdef ARB_LOCK_EN
  logic locked;
  assign pick_pending = locked ? (pending & owner_mask) : pending;
`else
  assign pick_pending = pending;
`endif

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .pending (pick_pending),
    .rr_ptr  (rr_ptr),
    .valid   (pick_valid),
    .index   (pick_index)
  );

  // Latch request pulses into slots; a pulse for the completing owner is
  // accepted (set beats clear), any other pulse on a pending slot overflows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending      <= '0;
      overflow_err <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_func[i]  <= '0;
        slot_addr1[i] <= '0;
        slot_addr2[i] <= '0;
        slot_wdata[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (completing && (grant_id == IDX_W'(i))) begin
          pending[i] <= 1'b0;
        end
        if (req_execute[i]) begin
          if (pending[i] && !(completing && (grant_id == IDX_W'(i)))) begin
            overflow_err <= 1'b1;
          end else begin
            pending[i]    <= 1'b1;
            slot_func[i]  <= req_func[2*i +: 2];
            slot_addr1[i] <= req_addr1[ADDR_W*i +: ADDR_W];
            slot_addr2[i] <= req_addr2[ADDR_W*i +: ADDR_W];
            slot_wdata[i] <= req_write_data[DATA_W*i +: DATA_W];
          end
        end
      end
    end
  end

  // Issue/complete FSM: grant in IDLE, then wait for mem_ready or timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= IDX_W'(NUM_REQ - 1);
      grant_id    <= '0;
      wait_cnt    <= '0;
      mem_execute <= 1'b0;
      mem_func    <= '0;
      address1    <= '0;
      address2    <= '0;
      write_data  <= '0;
      req_ready   <= '0;
      read_data1  <= '0;
      read_data2  <= '0;
      timeout_err <= 1'b0;
`ifdef ARB_LOCK_EN
      locked      <= 1'b0;
`endif
    end else begin
      mem_execute <= 1'b0;
      req_ready   <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            mem_execute <= 1'b1;
            mem_func    <= slot_func[pick_index];
            address1    <= slot_addr1[pick_index];
            address2    <= slot_addr2[pick_index];
            write_data  <= slot_wdata[pick_index];
            grant_id    <= pick_index;
            rr_ptr      <= pick_index;
            wait_cnt    <= '0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (completing) begin
            req_ready <= owner_mask;
            wait_cnt  <= '0;
            state     <= IDLE;
            if (mem_ready) begin
              read_data1 <= mem_read_data1;
              read_data2 <= mem_read_data2;
            end else begin
              timeout_err <= 1'b1;
              read_data1  <= '0;
              read_data2  <= '0;
            end
`ifdef ARB_LOCK_EN
            locked <= req_lock[grant_id];
`endif
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares the single memory unit port (execute/func/address1/address2/write_data in; ready/read_data1/read_data2 out) between NUM_REQ requesters: traversal, execute, edit block. Each requester keeps its existing one-cycle `mem_execute` pulse protocol. The arbiter latches the request, issues exactly one transaction to memory at a time, and returns a one-cycle per-requester ready together with the registered read data. It sits between the requester FSMs and the memory unit, replacing static mux selection.

## Interface
- NUM_REQ, 3, number of requesters; index 0 = traversal, 1 = execute, 2 = edit.
- ADDR_W, `memory_addr_width, address width.
- DATA_W, `memory_data_width, data word width.
- TIMEOUT, 255, maximum cycles spent in WAIT before abort; 8-bit counter.
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  reset, asynchronous and active-high.
- req_execute  in  NUM_REQ  per-requester request pulse.
- req_func  in  2*NUM_REQ  per-requester `GET_CONTENTS`/`SET_CONTENTS` code.
- req_addr1, req_addr2  in  ADDR_W*NUM_REQ  per-requester addresses.
- req_write_data  in  DATA_W*NUM_REQ  per-requester write word.
- req_ready  out  NUM_REQ  one-hot completion pulse.
- read_data1, read_data2  out  DATA_W  registered read data, broadcast to all requesters.
- mem_execute  out  1  issue pulse to memory.
- mem_func  out  2  function code to memory.
- address1, address2  out  ADDR_W  addresses to memory.
- write_data  out  DATA_W  write word to memory.
- mem_ready  in  1  memory completion.
- mem_read_data1, mem_read_data2  in  DATA_W  raw memory read data.
- grant_id  out  2  current or last owner.
- busy  out  1  high when state is not IDLE.
- arb_error  out  2  sticky error bits: [0] overflow, [1] timeout.

## Operation
- Capture: on req_execute[i], the arbiter latches func/addr1/addr2/wdata into slot i and sets pending[i].
- Overflow: a req_execute[i] arriving while pending[i] is set or i is the active owner sets arb_error[0]; that request is dropped.
- FSM state IDLE, when any pending bit is set:
  - rr_picker selects the first pending index, searching from rr_ptr+1 modulo NUM_REQ.
  - The slot contents are registered onto the memory outputs, mem_execute<=1, grant_id<=index, rr_ptr<=index.
  - Next state is WAIT.
- FSM state WAIT:
  - mem_execute is forced to 0 after its single cycle high.
  - When mem_ready is sampled high: read_data1/2<=mem_read_data1/2, req_ready[grant_id]<=1 for one cycle, pending[grant_id] cleared, wait counter cleared, next state IDLE.
  - When the wait counter reaches TIMEOUT without mem_ready: arb_error[1] set, read_data1/2<=0, req_ready pulses, next state IDLE.
- Simultaneous set and clear of pending[i]: set wins; the new request is queued.
- Requests arriving while busy are queued; they are never lost unless they hit the overflow rule.
- Reset, including mid-transaction: all outputs and registers go to 0 immediately; rr_ptr=NUM_REQ-1, so requester 0 wins first; state=IDLE. An in-flight memory op is abandoned.

## Timing
- Cycle T: req_execute sampled.
- T+1: IDLE selects the request.
- T+2: mem_execute is high for exactly one cycle.
- mem_ready sampled at cycle M → req_ready and read_data valid at M+1.
- Single-requester latency from request to req_ready = memory latency + 3 cycles.
- Back-to-back issue: at least 1 IDLE cycle between transactions.
- read_data1/2 hold their value until the next completion.
- Fairness: with all requesters continuously pending, grants rotate 0,1,2,0…

## Configuration
- ARB_LOCK_EN defined:
  - Adds input req_lock (NUM_REQ).
  - If req_lock[grant_id] is high when the owner's transaction completes, the owner stays locked.
  - While locked, IDLE considers only that owner's pending bit. Other requests queue.
  - The lock releases when the owner completes a transaction with req_lock low.
  - Intended for atomic edit read-modify-write.
- ARB_LOCK_EN undefined: the req_lock port is absent; arbitration is pure round-robin.

## Structure
- Header mem_arbiter.vh holds:
  - state encodings IDLE=2'h0, WAIT=2'h1;
  - requester index constants ARB_TRAV, ARB_EXEC, ARB_EDIT;
  - default TIMEOUT.
- Function codes come from memory_unit.vh.
- One sub-module, rr_picker: combinational rotate-priority encoder.
  - Inputs: pending, rr_ptr.
  - Outputs: valid, index.

## Test plan
- Requester 1 issues GET addr1=0x10; memory answers 2 cycles later with 0xABCD → mem_execute at T+2 with address1=0x10; req_ready[1] and read_data1=0xABCD at M+1; req_ready[0] and req_ready[2] stay 0.
- All three requesters pulse in the same cycle → grant order 0,1,2; each req_ready fires once; the memory sees three distinct addresses.
- Requester 2 pulses again while its first request is pending → arb_error[0]=1; only one transaction for requester 2 reaches memory.
- mem_ready held low → after 255 WAIT cycles arb_error[1]=1, req_ready pulses, read_data1=0, state returns to IDLE.
- rst asserted while in WAIT → mem_execute, busy and req_ready go 0 asynchronously; after release the first grant goes to requester 0.
- ARB_LOCK_EN: edit issues GET with req_lock=1 while traversal is pending → edit's following SET is granted before traversal.
